// File: rtl/rv32i_lsu_mem_port.sv
// rv32i_lsu_mem_port: RV32I load/store unit driving one request/grant/response data-memory port.
// Latency: store accept->o_done 2 cycles, load accept->o_wb_valid 3 cycles (minimum, gnt/rvalid immediate).
// Backpressure: one operation in flight; o_ready low from the cycle after acceptance until retire/error.
//
// Ports:
//   clk, rst_n                 core clock, async active-low reset
//   i_valid / o_ready          operation handshake (accepted on i_valid && o_ready)
//   i_is_load, i_is_store      operation class; both or neither is illegal
//   i_f3, i_addr, i_wdata, i_rd  funct3, effective byte address, store data, load destination
//   o_mem_req/i_mem_gnt        memory request handshake; we/addr/be/wdata held until grant
//   i_mem_rvalid/i_mem_rdata   read response, only sampled while waiting for it
//   o_wb_valid/o_wb_rd/o_wb_data  load writeback (one-cycle pulse, data held between loads)
//   o_done, o_err, o_err_cause  retire pulse, error pulse, sticky error cause
module rv32i_lsu_mem_port #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_is_load,
  input  logic        i_is_store,
  input  logic [2:0]  i_f3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_rd,
  output logic        o_mem_req,
  input  logic        i_mem_gnt,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_cause
);

  // Counter only has to reach TIMEOUT_CYC-1; the expiry check fires on that count.
  localparam int unsigned CNT_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  localparam logic [1:0] CAUSE_MISAL   = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q;
  logic        ready_q;
  logic        is_load_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_be_q;
  logic [31:0] mem_wdata_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        done_q;
  logic        err_q;
  logic [1:0]  err_cause_q;

  // Acceptance-time decode of the incoming operation.
  logic        op_load_d;
  logic        op_store_d;
  logic        illegal_d;
  logic        misal_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  always_comb begin
    op_load_d  = i_is_load & ~i_is_store;
    op_store_d = i_is_store & ~i_is_load;

    // Anything that is not exactly one of load/store stays illegal.
    illegal_d = 1'b1;
    if (op_load_d) begin
      case (i_f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_d = 1'b0;
        default:                                illegal_d = 1'b1;
      endcase
    end else if (op_store_d) begin
      case (i_f3)
        3'b000, 3'b001, 3'b010: illegal_d = 1'b0;
        default:                illegal_d = 1'b1;
      endcase
    end

    // f3[1:0] encodes access size for every legal load/store.
    misal_d = 1'b0;
    case (i_f3[1:0])
      2'b01:   misal_d = i_addr[0];
      2'b10:   misal_d = |i_addr[1:0];
      default: misal_d = 1'b0;
    endcase

    case (i_f3[1:0])
      2'b00:   be_d = 4'b0001 << i_addr[1:0];
      2'b01:   be_d = 4'b0011 << i_addr[1:0];
      default: be_d = 4'b1111;
    endcase

    // Replicating store data across lanes makes it valid for any offset; be picks the lane.
    wdata_d = 32'h0;
    if (op_store_d) begin
      case (i_f3[1:0])
        2'b00:   wdata_d = {4{i_wdata[7:0]}};
        2'b01:   wdata_d = {2{i_wdata[15:0]}};
        default: wdata_d = i_wdata;
      endcase
    end
  end

  // Load data extraction: bring the addressed lane down to bit 0, then extend.
  logic [31:0] rd_shift;
  logic [31:0] ld_ext;

  always_comb begin
    rd_shift = i_mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'h0, rd_shift[15:0]};
      default: ld_ext = rd_shift;
    endcase
  end

  // Single-process FSM; every output is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b1;
      is_load_q   <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      rd_q        <= 5'd0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cause_q <= 2'b00;
    end else begin
      // Pulses default low; set only on the transition that produces them.
      wb_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (i_valid && ready_q) begin
            ready_q   <= 1'b0;
            is_load_q <= op_load_d;
            f3_q      <= i_f3;
            off_q     <= i_addr[1:0];
            rd_q      <= i_rd;
            if (illegal_d) begin
              state_q     <= S_ERR;
              err_q       <= 1'b1;
              err_cause_q <= CAUSE_ILLEGAL;
            end else if (misal_d) begin
              state_q     <= S_ERR;
              err_q       <= 1'b1;
              err_cause_q <= CAUSE_MISAL;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= op_store_d;
              mem_addr_q  <= {i_addr[31:2], 2'b00};
              mem_be_q    <= be_d;
              mem_wdata_q <= wdata_d;
            end
          end
        end

        S_REQ: begin
          // rvalid in the grant cycle is deliberately not looked at here.
          if (i_mem_gnt) begin
            mem_req_q <= 1'b0;
            if (is_load_q) begin
              state_q <= S_WAIT;
              cnt_q   <= '0;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        S_WAIT: begin
          if (i_mem_rvalid) begin
            state_q    <= S_DONE;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= ld_ext;
            done_q     <= 1'b1;
          end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TO_LAST))) begin
            state_q     <= S_ERR;
            err_q       <= 1'b1;
            err_cause_q <= CAUSE_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        // Both states exist only to show their pulse for one cycle.
        S_DONE, S_ERR: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q   <= S_IDLE;
          ready_q   <= 1'b1;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready     = ready_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_be    = mem_be_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_wb_valid  = wb_valid_q;
  assign o_wb_rd     = wb_rd_q;
  assign o_wb_data   = wb_data_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_err_cause = err_cause_q;

endmodule

// File: doc/rv32i_lsu_mem_port.md
Name: rv32i_lsu_mem_port

Overview:
Execution-side load/store unit for the RV32I core. It accepts a decoded load or store whose effective address comes from the ALU (ADD of rs1 and the I/S immediate) and performs one request/grant/response transaction on a 32-bit data-memory port. It generates byte enables and lane-shifted write data for stores, and extracts plus sign/zero-extends read data for loads. It sits between the decode/ALU stage and the data memory, and returns load results to register writeback.

Parameters:
TIMEOUT_CYC, 64, max cycles waiting in S_WAIT for i_mem_rvalid before aborting with a bus error; 0 disables the timeout.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  operation valid; accepted when i_valid && o_ready
o_ready  out  1  LSU idle and able to accept an operation
i_is_load  in  1  operation is a load (opcode 0000011)
i_is_store  in  1  operation is a store (opcode 0100011)
i_f3  in  3  funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
i_addr  in  32  effective byte address (ALU result)
i_wdata  in  32  store data (rs2)
i_rd  in  5  load destination register
o_mem_req  out  1  memory request
i_mem_gnt  in  1  memory accepts the request this cycle
o_mem_we  out  1  1 = write
o_mem_addr  out  32  word address, {addr[31:2], 2'b00}
o_mem_be  out  4  byte enables
o_mem_wdata  out  32  lane-aligned write data
i_mem_rvalid  in  1  read data valid
i_mem_rdata  in  32  read data word
o_wb_valid  out  1  one-cycle pulse: load result valid
o_wb_rd  out  5  load destination register
o_wb_data  out  32  extended load result
o_done  out  1  one-cycle pulse: operation retired (load or store, no error)
o_err  out  1  one-cycle pulse: misaligned, illegal f3, or timeout
o_err_cause  out  2  01 misaligned, 10 illegal, 11 timeout; held until the next error

Behaviour:
- Reset (async, rst_n=0): state S_IDLE; o_ready=1; every other output 0; timeout counter 0. If rst_n asserts mid-transaction, the operation is dropped and no pulse is generated.
- Acceptance: in S_IDLE on i_valid && o_ready, latch addr, wdata, f3, rd and the load/store flag. o_ready drops the next cycle.
- Operation with both i_is_load and i_is_store set, or neither set: treated as illegal.
- Checks on acceptance, evaluated in this order, both leading to S_ERR:
  - Illegal: f3 not in the list for that operation type. Cause 10.
  - Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0. Cause 01.
  - No memory request is issued for either case.
- S_ERR: o_err=1 for one cycle, then S_IDLE.
- S_REQ:
  - o_mem_req=1 with o_mem_we/o_mem_addr/o_mem_be/o_mem_wdata stable until i_mem_gnt is sampled high.
  - Store on gnt goes to S_DONE. Load on gnt goes to S_WAIT.
  - The earliest request is the cycle after acceptance.
- Byte enables, with off = addr[1:0]:
  - Byte: be = 0001<<off.
  - Half: be = 0011<<off.
  - Word: be = 1111.
  - Loads use the same be.
- Write data:
  - SB: wdata[7:0] replicated to all 4 lanes.
  - SH: wdata[15:0] replicated to both halves.
  - SW: unchanged.
  - Loads drive 0.
- S_WAIT:
  - On i_mem_rvalid, extract data = rdata >> (8*off).
  - LB and LH sign-extend bit 7 / bit 15. LBU and LHU zero-extend. LW passes through.
  - Register the result into o_wb_data and set o_wb_valid=1, o_wb_rd=rd and o_done=1 for one cycle, then S_IDLE.
  - i_mem_rvalid in the same cycle as gnt is not valid; rvalid is only sampled in S_WAIT.
- Timeout: the counter increments each S_WAIT cycle and is cleared on S_WAIT entry. When it reaches TIMEOUT_CYC without rvalid, go to S_ERR with cause 11. A late rvalid arriving in S_IDLE is ignored.
- S_DONE (store): o_done=1 for one cycle, then S_IDLE.
- Throughput: one operation at a time.
  - Minimum store latency: accept to o_done = 2 cycles, with gnt on the first request cycle.
  - Minimum load latency: accept to o_wb_valid = 3 cycles.
- o_wb_data holds its last value between loads. o_wb_rd is meaningful only while o_wb_valid is high.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, gnt immediate -> req: addr 0x100, be 1111, wdata 0xDEADBEEF, we=1. o_done 2 cycles after accept. No o_wb_valid.
- SB addr 0x203, wdata 0x000000A5, gnt held low 3 cycles -> req held stable 4 cycles: addr 0x200, be 1000, wdata 0xA5A5A5A5.
- LB addr 0x301 with rdata 0x1234_80FF; LBU same address; LH addr 0x302 with rdata 0x8001_0000 -> o_wb_data 0xFFFFFF80, then 0x00000080, then 0xFFFF8001. Each with o_wb_rd as issued.
- LW addr 0x102 -> o_err with cause 01, no o_mem_req ever asserted. Store with f3=011 -> o_err with cause 10.
- Load with TIMEOUT_CYC=4 and rvalid never asserted -> o_err with cause 11 after 4 S_WAIT cycles, o_ready=1 the next cycle. A late rvalid is then ignored: no o_wb_valid.
- Assert rst_n=0 during S_WAIT -> outputs cleared immediately and o_ready=1. A following LW returns correct data.
